// File: rtl/merge_sched_pkg.sv
// Shared types and parameter defaults for the merge scheduler.
package merge_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GUARD = 1'b1
    } state_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    localparam int GUARD_CYCLES_DEF = 3;
    localparam int PEND_MAX_DEF     = 7;
    localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/merge_sched_pend.sv
// One requester lane: edge detect on the input level, saturating pending count, sticky drop flag.
module merge_sched_pend
    import merge_sched_pkg::*;
#(
    parameter int PEND_MAX = PEND_MAX_DEF,
    parameter int PW       = $clog2(PEND_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          x,
    input  logic          grant,
    output logic [PW-1:0] pend,
    output logic          ovf
);

    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

    logic x_d;
    logic ev;

    assign ev = x ^ x_d;

    // x_d follows the input even in reset so release never fakes an event.
    always_ff @(posedge clk) begin
        x_d <= x;
        if (!rst_n) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else if (ev && !grant) begin
            if (pend == PEND_FULL) begin
                ovf <= 1'b1;
            end else begin
                pend <= pend + 1'b1;
            end
        end else if (!ev && grant) begin
            pend <= pend - 1'b1;
        end
    end

endmodule

// File: rtl/merge_scheduler.sv
// Merges two edge-encoded event streams onto q with round-robin arbitration and a guard gap.
// Optional statistics counters n_out/n_coll are built when MERGE_SCHED_STATS_EN is defined.
//
// state | meaning
// IDLE  | may grant one pending input and toggle q
// GUARD | guard_cnt counting down, no grants
module merge_scheduler
    import merge_sched_pkg::*;
#(
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
    parameter int PEND_MAX     = PEND_MAX_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             q,
    output logic             busy,
    output logic             ovf_a,
    output logic             ovf_b
`ifdef MERGE_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] n_out,
    output logic [CNT_W-1:0] n_coll
`endif
);

    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

    logic [PW-1:0] pend_a;
    logic [PW-1:0] pend_b;
    logic          grant_a;
    logic          grant_b;
    logic          sel_a;
    state_t        state;
    sel_t          last_sel;
    logic [GW-1:0] guard_cnt;

    merge_sched_pend #(
        .PEND_MAX (PEND_MAX),
        .PW       (PW)
    ) u_pend_a (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (a),
        .grant (grant_a),
        .pend  (pend_a),
        .ovf   (ovf_a)
    );

    merge_sched_pend #(
        .PEND_MAX (PEND_MAX),
        .PW       (PW)
    ) u_pend_b (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (b),
        .grant (grant_b),
        .pend  (pend_b),
        .ovf   (ovf_b)
    );

    // A wins when it is alone, or when both wait and B was served last.
    always_comb begin
        sel_a   = (pend_a != '0) && ((pend_b == '0) || (last_sel == SEL_B));
        grant_a = (state == IDLE) && sel_a;
        grant_b = (state == IDLE) && (pend_b != '0) && !sel_a;
    end

    assign busy = (state != IDLE) || (pend_a != '0) || (pend_b != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            guard_cnt <= '0;
            q         <= 1'b0;
            last_sel  <= SEL_B;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        q        <= ~q;
                        last_sel <= grant_a ? SEL_A : SEL_B;
                        if (GUARD_CYCLES > 0) begin
                            state     <= GUARD;
                            guard_cnt <= GUARD_LOAD;
                        end
                    end
                end
                GUARD: begin
                    guard_cnt <= guard_cnt - 1'b1;
                    if (guard_cnt == GW'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    guard_cnt <= '0;
                end
            endcase
        end
    end

`ifdef MERGE_SCHED_STATS_EN
    logic both_pend;

    assign both_pend = (pend_a != '0) && (pend_b != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_out  <= '0;
            n_coll <= '0;
        end else if (grant_a || grant_b) begin
            if (n_out != '1) begin
                n_out <= n_out + 1'b1;
            end
            if (both_pend && (n_coll != '1)) begin
                n_coll <= n_coll + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/merge_scheduler.md
MERGE_SCHEDULER -- requirements
Module: merge_scheduler

Interface
REQ-001 The block SHALL have parameter GUARD_CYCLES, default 3, giving the number of idle cycles forced after each output toggle.
REQ-002 The block SHALL have parameter PEND_MAX, default 7, giving the maximum pending events per input (counter width clog2(PEND_MAX+1)).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port a, input, 1 bit: requester A, edge-encoded; each level change is one pulse event.
REQ-007 The block SHALL have port b, input, 1 bit: requester B, edge-encoded; each level change is one pulse event.
REQ-008 The block SHALL have port q, output, 1 bit: merged output, edge-encoded; each toggle is one forwarded event.
REQ-009 The block SHALL have port busy, output, 1 bit: high when any event is pending or the FSM is not IDLE.
REQ-010 The block SHALL have ports ovf_a and ovf_b, output, 1 bit each: sticky drop flags for inputs A and B.
REQ-011 The block SHALL have ports n_out and n_coll, output, CNT_W bits each: statistics counters, present only per REQ-030.

Function
REQ-012 Input event detection SHALL be done by registering a_d/b_d; an event is flagged when a != a_d (likewise b), with a_d <= a every cycle.
REQ-013 Each input event SHALL increment its pending counter pend_a/pend_b in the cycle it is detected.
REQ-014 An event arriving when pend = PEND_MAX with no same-cycle grant on that input SHALL be dropped and SHALL set the matching ovf flag, which stays set until reset.
REQ-015 An event and a grant on the same input in the same cycle SHALL leave that counter unchanged.
REQ-016 The FSM SHALL have two states: IDLE and GUARD.
REQ-017 In IDLE with pend_a>0 or pend_b>0, the block SHALL grant exactly one input, toggle q at that clock edge and decrement the granted counter.
REQ-018 After a grant, the FSM SHALL go to GUARD when GUARD_CYCLES>0, or stay in IDLE when GUARD_CYCLES=0.
REQ-019 GUARD SHALL load a down-counter with GUARD_CYCLES, forbid any grant, and return to IDLE when the counter expires.
REQ-020 Successive q toggles SHALL therefore be at least GUARD_CYCLES+1 cycles apart.
REQ-021 When only one input is pending, that input SHALL be granted.
REQ-022 When both inputs are pending, round-robin SHALL apply: grant the input not granted last; after reset B counts as last granted, so A goes first.
REQ-023 Latency SHALL be 2 rising edges, idle and empty: edge k detects the event and sets pend; edge k+1 grants and q toggles.
REQ-024 Events on a and b in the same cycle SHALL both be accepted (both counters increment), then served in round-robin order, GUARD_CYCLES+1 cycles apart.
REQ-025 Event counts SHALL be conserved: q toggles = accepted events, with no merging of coincident events.

Reset
REQ-026 While rst_n=0 at a rising edge: q=0, state=IDLE, guard counter=0, pend_a=pend_b=0, ovf_a=ovf_b=0, round-robin pointer=B, counters=0.
REQ-027 During reset, a_d<=a and b_d<=b, so no event is detected in the first cycle after release.
REQ-028 Reset asserted mid-GUARD or with events pending SHALL discard all pending events; busy=0 in the first cycle after release.
REQ-029 busy SHALL be derived combinationally from registered state only.

Configuration
REQ-030 With macro MERGE_SCHED_STATS_EN defined: n_out counts q toggles; n_coll counts grants made with both inputs pending; both saturate at all-ones and are cleared by reset.
REQ-031 Without MERGE_SCHED_STATS_EN: ports n_out and n_coll and their logic are absent.

Structure
REQ-032 A shared package merge_sched_pkg SHALL hold the FSM state typedef (IDLE, GUARD), the input-select enum (SEL_A, SEL_B) and the parameter defaults.
REQ-033 There SHALL be one sub-module, merge_sched_pend, instantiated twice: edge detect, saturating pending counter and ovf flag for one input.

Verification
REQ-034 Reset, then a toggles once at cycle 10 -> q toggles once at edge 11; busy high for cycles 10-14; n_out=1.
REQ-035 a and b toggle in the same cycle 20 -> q toggles at 21 (A) and 25 (B); n_coll=1; no ovf.
REQ-036 8 a toggles on consecutive cycles with PEND_MAX=7, GUARD_CYCLES=3 -> all 8 accepted, q toggles 8 times spaced 4 cycles apart, ovf_a=0.
REQ-037 12 a toggles on consecutive cycles -> events in excess of PEND_MAX after grants are dropped, ovf_a=1, and the number of q toggles equals the number of accepted events.
REQ-038 rst_n low for 1 cycle while pend_a=3 in GUARD -> pend cleared, q=0, no further toggles, busy=0.
REQ-039 GUARD_CYCLES=0, alternating a/b toggles every cycle -> q toggles every cycle, order A,B,A,B.
